hazard_unit: RTL and testbench

- Stall/flush controller for the 5-stage pipeline. It resolves the hazards that operand bypassing cannot cover: load-use, instruction-cache miss, data-cache wait, taken branch/jump redirect, and halt.
- It drives per-latch enable/flush signals and the PC enable. It keeps a small state machine (RUN/DWAIT/HALTED) and a saturating stall-cycle counter.
- It sits beside the datapath latches, between the caches and the pipeline registers.

---
 rtl/hazard_unit.sv | 173 +++++++++++++++++
 tb/tb_hazard_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//
// Stall/flush controller for the 5-stage pipeline. It resolves the hazards
// that operand bypassing cannot cover: load-use, icache miss, dcache wait,
// taken branch/jump redirect, and halt. It drives the PC enable plus the
// enable/flush pair of every pipeline latch.
//
// Ports
//   CLK, RST              pipeline clock, asynchronous active-high reset
//   ihit                  icache delivers a valid instruction this cycle
//   dhit                  dcache completes the MEM-stage access this cycle
//   mem_dREN, mem_dWEN    MEM-stage load / store request
//   ex_MemRead, ex_regRt  EX-stage instruction is a load, and its dest reg
//   id_regRs, id_regRt    source registers of the ID-stage instruction
//   id_usesRt             ID instruction really reads Rt
//   mem_redirect          taken branch/jump resolved in MEM
//   wb_halt               HALT instruction in WB
//   pc_en, *_en           PC / latch enables
//   *_flush               latch loads a bubble (nop, all controls 0)
//   dwait                 state is DWAIT
//   halted                state is HALTED (sticky until RST)
//   stall_cnt             saturating count of pc_en=0 cycles outside HALTED
//
// Handshake: there is no valid/ready protocol here. ihit and dhit are
// single-cycle completion strobes sampled combinationally; every output is a
// zero-latency function of the registered state and the current inputs.
// ---------------------------------------------------------------------------
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_regRt,
    input  logic [4:0]       id_regRs,
    input  logic [4:0]       id_regRt,
    input  logic             id_usesRt,
    input  logic             mem_redirect,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             dwait,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic memmiss;
    logic loaduse;

    assign memmiss = (mem_dREN | mem_dWEN) & ~dhit;

    // $0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign loaduse = ex_MemRead & (ex_regRt != 5'd0) &
                     ((ex_regRt == id_regRs) |
                      (id_usesRt & (ex_regRt == id_regRt)));

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. WB is bubbled throughout DWAIT, so wb_halt cannot
    // arrive there and DWAIT only ever returns to RUN.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (wb_halt) begin
                    state_next = HALTED;
                end else if (memmiss) begin
                    state_next = DWAIT;
                end
            end
            DWAIT: begin
                if (dhit) begin
                    state_next = RUN;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Output logic, highest priority first. A redirect that coincides with a
    // dcache miss is simply not seen: the freeze holds the branch in MEM and
    // the redirect takes effect in the dhit cycle.
    always_comb begin
        pc_en       = ihit;
        ifid_en     = ihit;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;

        if (state == HALTED || wb_halt) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (memmiss) begin
            // Freeze everything up to MEM; WB takes a bubble so the stalled
            // MEM instruction is never retired twice.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (mem_redirect) begin
            // The target is loaded even if the icache is still missing.
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (loaduse) begin
            // One bubble: next cycle EX holds the nop and the hazard is gone.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (!ihit) begin
            // pc_en / ifid_en already follow ihit; the flush pushes a nop
            // into ID so downstream latches keep draining.
            ifid_flush = 1'b1;
        end
    end

    assign dwait  = (state == DWAIT);
    assign halted = (state == HALTED);

    // Stall-cycle counter, saturating at all-ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
        end else if (!pc_en && state != HALTED &&
                     stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
//
// Bench for hazard_unit (CNT_W=4 so saturation is reachable quickly).
// Phases: combinational vector table with RST held, directed multi-cycle
// sequences, then randomized cycles against a behavioural model.
// Output vector order: {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//                       ifid_flush, idex_flush, exmem_flush, memwb_flush}
// ---------------------------------------------------------------------------
module tb_hazard_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    // Output patterns derived from the hazard rules
    localparam logic [8:0] O_RUN   = 9'b11111_0000;
    localparam logic [8:0] O_IMISS = 9'b00111_1000;
    localparam logic [8:0] O_LU    = 9'b00111_0100;
    localparam logic [8:0] O_REDIR = 9'b11111_1110;
    localparam logic [8:0] O_MISS  = 9'b00001_0001;
    localparam logic [8:0] O_HALT  = 9'b00000_0000;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic ihit, dhit, mem_dREN, mem_dWEN, ex_MemRead, id_usesRt;
    logic mem_redirect, wb_halt;
    logic [4:0] ex_regRt, id_regRs, id_regRt;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic dwait, halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [8:0] outs;

    assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, exmem_flush, memwb_flush};

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .ex_MemRead(ex_MemRead), .ex_regRt(ex_regRt),
        .id_regRs(id_regRs), .id_regRt(id_regRt), .id_usesRt(id_usesRt),
        .mem_redirect(mem_redirect), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .dwait(dwait), .halted(halted), .stall_cnt(stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        ex_MemRead = 1'b0; ex_regRt = 5'd0; id_regRs = 5'd0;
        id_regRt = 5'd0; id_usesRt = 1'b0; mem_redirect = 1'b0;
        wb_halt = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        idle_inputs();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // ---------------- behavioural reference ----------------
    bit m_halted;
    bit m_wait;
    int m_cnt;

    function automatic logic [8:0] ref_out(input bit is_halted);
        bit miss, lu;
        miss = (mem_dREN || mem_dWEN) && !dhit;
        lu   = ex_MemRead && ex_regRt != 0 &&
               (ex_regRt == id_regRs || (id_usesRt && ex_regRt == id_regRt));
        if (is_halted || wb_halt) return O_HALT;
        if (miss)                 return O_MISS;
        if (mem_redirect)         return O_REDIR;
        if (lu)                   return O_LU;
        if (!ihit)                return O_IMISS;
        return O_RUN;
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step();
        logic [8:0] o;
        bit miss;
        o = ref_out(m_halted);
        miss = (mem_dREN || mem_dWEN) && !dhit;
        if (!m_halted) begin
            if (o[8] == 1'b0 && m_cnt < CNT_MAX) m_cnt++;
            if (m_wait) begin
                if (dhit) m_wait = 0;
            end else if (wb_halt) begin
                m_halted = 1;
            end else if (miss) begin
                m_wait = 1;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       ihit, dhit, dren, dwen, exmr;
        logic [4:0] ex_rt, id_rs, id_rt;
        logic       uses_rt, redir, halt;
        logic [8:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic ih, dh, dr, dw, mr,
                                input logic [4:0] ert, irs, irt,
                                input logic ur, rd, hl,
                                input logic [8:0] e);
        vec_t v;
        v.ihit = ih; v.dhit = dh; v.dren = dr; v.dwen = dw; v.exmr = mr;
        v.ex_rt = ert; v.id_rs = irs; v.id_rt = irt;
        v.uses_rt = ur; v.redir = rd; v.halt = hl; v.exp = e;
        return v;
    endfunction

    vec_t vecs[15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();

        //            ih dh dr dw mr ert irs irt ur rd hl exp
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IMISS);
        vecs[2]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_MISS);
        vecs[3]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, O_MISS);
        vecs[4]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_REDIR);
        vecs[6]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, O_MISS);
        vecs[7]  = mk(1, 0, 0, 0, 1, 5, 5, 1, 0, 0, 0, O_LU);
        vecs[8]  = mk(1, 0, 0, 0, 1, 7, 1, 7, 1, 0, 0, O_LU);
        vecs[9]  = mk(1, 0, 0, 0, 1, 7, 1, 7, 0, 0, 0, O_RUN);
        vecs[10] = mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, O_RUN);
        vecs[11] = mk(0, 0, 0, 0, 1, 3, 3, 0, 0, 0, 0, O_LU);
        vecs[12] = mk(1, 0, 0, 0, 1, 3, 3, 0, 0, 1, 0, O_REDIR);
        vecs[13] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, O_HALT);
        vecs[14] = mk(1, 0, 0, 0, 0, 9, 9, 9, 1, 0, 0, O_RUN);

        // Reset state, and combinational table with RST held (state = RUN)
        #2;
        chk("reset_stall_cnt", 32'(stall_cnt), 0);
        chk("reset_dwait", 32'(dwait), 0);
        chk("reset_halted", 32'(halted), 0);
        chk("reset_outs", 32'(outs), 32'(O_RUN));
        for (int i = 0; i < 15; i++) begin
            ihit = vecs[i].ihit; dhit = vecs[i].dhit;
            mem_dREN = vecs[i].dren; mem_dWEN = vecs[i].dwen;
            ex_MemRead = vecs[i].exmr; ex_regRt = vecs[i].ex_rt;
            id_regRs = vecs[i].id_rs; id_regRt = vecs[i].id_rt;
            id_usesRt = vecs[i].uses_rt; mem_redirect = vecs[i].redir;
            wb_halt = vecs[i].halt;
            #1;
            chk($sformatf("table_outs[%0d]", i), 32'(outs), 32'(vecs[i].exp));
        end

        // Load-use: exactly one bubble
        do_reset();
        ex_MemRead = 1'b1; ex_regRt = 5'd2; id_regRs = 5'd2;
        #1 chk("lu_stall_outs", 32'(outs), 32'(O_LU));
        @(negedge CLK);
        ex_MemRead = 1'b0;
        #1 chk("lu_next_run", 32'(outs), 32'(O_RUN));
        chk("lu_stall_cnt", 32'(stall_cnt), 1);
        // Load to $0 never stalls
        ex_MemRead = 1'b1; ex_regRt = 5'd0; id_regRs = 5'd0;
        #1 chk("lu_r0_outs", 32'(outs), 32'(O_RUN));
        @(negedge CLK);
        chk("lu_r0_cnt", 32'(stall_cnt), 1);

        // dcache miss for 3 cycles then hit
        do_reset();
        mem_dREN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dhit = 1'b0;
            #1 chk($sformatf("miss_outs[%0d]", i), 32'(outs), 32'(O_MISS));
            @(posedge CLK); #1;
            chk($sformatf("miss_dwait[%0d]", i), 32'(dwait), 1);
            @(negedge CLK);
        end
        dhit = 1'b1;
        #1 chk("miss_release_outs", 32'(outs), 32'(O_RUN));
        @(posedge CLK); #1;
        chk("miss_release_dwait", 32'(dwait), 0);
        chk("miss_stall_cnt", 32'(stall_cnt), 3);

        // Redirect held off by the miss, applied on the dhit cycle
        do_reset();
        mem_dREN = 1'b1; mem_redirect = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dhit = 1'b0;
            #1 chk($sformatf("redir_miss_outs[%0d]", i), 32'(outs), 32'(O_MISS));
            @(negedge CLK);
        end
        dhit = 1'b1;
        #1 chk("redir_release_outs", 32'(outs), 32'(O_REDIR));
        @(posedge CLK); #1;
        chk("redir_stall_cnt", 32'(stall_cnt), 2);

        // Halt: same-cycle freeze, registered sticky halted
        do_reset();
        wb_halt = 1'b1;
        #1 chk("halt_outs_now", 32'(outs), 32'(O_HALT));
        chk("halt_not_yet", 32'(halted), 0);
        @(negedge CLK);
        wb_halt = 1'b0;
        #1 chk("halt_sticky", 32'(halted), 1);
        for (int i = 0; i < 6; i++) begin
            ihit = 1'($urandom); dhit = 1'($urandom);
            mem_dREN = 1'($urandom); mem_redirect = 1'($urandom);
            ex_MemRead = 1'($urandom);
            @(negedge CLK); #1;
            chk($sformatf("halt_hold_outs[%0d]", i), 32'(outs), 32'(O_HALT));
            chk($sformatf("halt_hold[%0d]", i), 32'(halted), 1);
        end
        // Only the RUN-state wb_halt cycle counts
        chk("halt_stall_cnt", 32'(stall_cnt), 1);

        // Saturation and asynchronous clear
        do_reset();
        ihit = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (i == 10 || i == 15 || i == 20)
                chk($sformatf("sat_cnt[%0d]", i), 32'(stall_cnt),
                    32'(i < CNT_MAX ? i : CNT_MAX));
        end
        RST = 1'b1;
        #1 chk("async_clear_cnt", 32'(stall_cnt), 0);
        chk("async_clear_halted", 32'(halted), 0);
        @(negedge CLK);
        RST = 1'b0;

        // Randomized cycles against the behavioural model
        for (int blk = 0; blk < 3; blk++) begin
            do_reset();
            m_halted = 0; m_wait = 0; m_cnt = 0;
            for (int c = 0; c < 150; c++) begin
                ihit = ($urandom_range(0, 3) != 0);
                dhit = 1'($urandom);
                mem_dREN = ($urandom_range(0, 3) == 0);
                mem_dWEN = ($urandom_range(0, 7) == 0);
                ex_MemRead = ($urandom_range(0, 2) == 0);
                ex_regRt = 5'($urandom_range(0, 3));
                id_regRs = 5'($urandom_range(0, 3));
                id_regRt = 5'($urandom_range(0, 3));
                id_usesRt = 1'($urandom);
                mem_redirect = ($urandom_range(0, 7) == 0);
                wb_halt = (!m_wait && $urandom_range(0, 119) == 0);
                #1 chk("rnd_outs", 32'(outs), 32'(ref_out(m_halted)));
                @(posedge CLK);
                model_step();
                #1;
                chk("rnd_dwait", 32'(dwait), 32'(m_wait));
                chk("rnd_halted", 32'(halted), 32'(m_halted));
                chk("rnd_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
                @(negedge CLK);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
